// File: rtl/interval_timer_ctrl.sv
// Round-robin owner of a shared up-counter: grants one of two requesters,
// clears and steps the counter to the latched target, then pulses done.
module interval_timer_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        COUNT,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             owner_nxt;
    logic             last;
    logic             last_nxt;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_nxt;
    logic             winner;
    logic             hold;
    logic [1:0]       owner_oh;

    assign owner_oh = owner ? 2'b10 : 2'b01;
    assign busy     = (state != IDLE);
    assign gnt      = busy ? owner_oh : 2'b00;
    assign hold     = req[owner];

    // On a tie the requester not granted last goes first.
    always_comb begin
        winner = ~last;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        last_nxt   = last;
        target_nxt = target;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        done       = 2'b00;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt  = CLEAR;
                    owner_nxt  = winner;
                    target_nxt = winner ? len1 : len0;
                end
            end
            CLEAR: begin
                cnt_clr = 1'b1;
                if (!hold) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end else begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (!hold) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end else if (cnt_q == target) begin
                    state_nxt = FINISH;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            FINISH: begin
                done      = owner_oh;
                state_nxt = IDLE;
                last_nxt  = owner;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            target <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            last   <= last_nxt;
            target <= target_nxt;
        end
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl: external counter, job-offset reference
// model compared every cycle, plus directed jobs with fixed expectations.
`timescale 1ns/1ps
module tb_interval_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] len0 = 4'd0;
    logic [3:0] len1 = 4'd0;
    logic [3:0] cnt_q = 4'd0;
    logic       cnt_clr;
    logic       cnt_en;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Reference model: a job is (owner, length, cycles since grant edge).
    logic m_act = 1'b0;
    logic m_own = 1'b0;
    logic m_last = 1'b1;
    int   m_len = 0;
    int   m_k = 0;

    interval_timer_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .cnt_q   (cnt_q),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_clr) cnt_q <= 4'd0;
        else if (cnt_en) cnt_q <= cnt_q + 4'd1;
    end

    function automatic logic m_abort();
        return m_act && !req[m_own] && (m_k <= m_len + 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act = 1'b0;
            m_last = 1'b1;
            m_k = 0;
        end else if (!m_act) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_own = ~m_last;
                else m_own = req[1];
                m_len = m_own ? int'(len1) : int'(len0);
                m_act = 1'b1;
                m_k = 0;
            end
        end else if (m_abort() || m_k == m_len + 2) begin
            m_act = 1'b0;
            m_last = m_own;
        end else begin
            m_k = m_k + 1;
        end
    end

    function automatic logic [6:0] model_out();
        logic [1:0] g;
        logic       en;
        if (!m_act) return 7'd0;
        g = m_own ? 2'b10 : 2'b01;
        en = !m_abort() && m_k >= 1 && m_k <= m_len;
        return {g, (m_k == m_len + 2) ? g : 2'b00, 1'b1, (m_k == 0), en};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("cycle", {25'd0, gnt, done, busy, cnt_clr, cnt_en}, {25'd0, model_out()});
    endtask

    task automatic run_single(input int idx, input int n);
        int lat;
        int ens;
        int bad_seq;
        logic [3:0] qd;
        lat = -1;
        ens = 0;
        bad_seq = 0;
        qd = 4'd0;
        req[idx] = 1'b1;
        if (idx == 0) len0 = n[3:0];
        else len1 = n[3:0];
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) check("grant", {30'd0, gnt}, 32'd1 << idx);
            if (k == 0) check("clear", {31'd0, cnt_clr}, 32'd1);
            if (cnt_en) ens++;
            if (k >= 1 && k <= n + 1 && int'(cnt_q) != k - 1) bad_seq++;
            if (done[idx]) begin
                lat = k;
                qd = cnt_q;
                break;
            end
        end
        check("done_latency", lat, n + 2);
        check("en_pulses", ens, n);
        check("q_at_done", {28'd0, qd}, n);
        check("count_seq", bad_seq, 0);
        tick();
        check("after_done", {27'd0, done, busy, gnt}, 32'd0);
        req[idx] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 2'b00;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int order[4];
        int gstart[4];
        int ng;
        int found;
        logic [1:0] prev;

        repeat (3) tick();
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_ctl", {29'd0, busy, cnt_clr, cnt_en}, 32'd0);
        reset_n = 1'b1;
        tick();

        run_single(0, 5);
        run_single(1, 0);
        run_single(0, 15);

        // Both held: strict alternation starting with requester 0.
        do_reset();
        len0 = 4'd2;
        len1 = 4'd3;
        req = 2'b11;
        ng = 0;
        prev = 2'b00;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            tick();
            if (gnt != 2'b00 && prev == 2'b00) begin
                order[ng] = gnt[1] ? 1 : 0;
                gstart[ng] = c;
                ng++;
            end
            prev = gnt;
        end
        for (int c = 0; c < 20 && done == 2'b00; c++) tick();
        req = 2'b00;
        check("tie_grants", ng, 4);
        check("tie_order0", order[0], 0);
        check("tie_order1", order[1], 1);
        check("tie_order2", order[2], 0);
        check("tie_order3", order[3], 1);
        check("tie_gap0", gstart[1] - gstart[0], 6);
        check("tie_gap1", gstart[2] - gstart[1], 7);
        check("tie_gap2", gstart[3] - gstart[2], 6);
        repeat (3) tick();

        // Abort requester 0 mid-count with requester 1 waiting.
        len0 = 4'd9;
        len1 = 4'd4;
        req = 2'b01;
        tick();
        req = 2'b11;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt == 2'b01 && cnt_q == 4'd3) begin
                found = 1;
                break;
            end
        end
        check("abort_reach", found, 1);
        #1 req[0] = 1'b0;
        #1 check("abort_en", {31'd0, cnt_en}, 32'd0);
        tick();
        check("abort_idle", {28'd0, gnt, done}, 32'd0);
        tick();
        check("abort_next", {30'd0, gnt}, 32'd2);
        for (int c = 0; c < 20 && done == 2'b00; c++) tick();
        req = 2'b00;
        repeat (2) tick();

        // Short reset pulse in the middle of a count.
        len0 = 4'd10;
        req = 2'b01;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cnt_q == 4'd4 && gnt == 2'b01) begin
                found = 1;
                break;
            end
        end
        check("rstpulse_reach", found, 1);
        #1 reset_n = 1'b0;
        #1 check("rstpulse_outs", {27'd0, gnt, done, busy}, 32'd0);
        check("rstpulse_en", {31'd0, cnt_en}, 32'd0);
        reset_n = 1'b1;
        found = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k == 0) check("regrant", {30'd0, gnt}, 32'd1);
            if (done[0]) begin
                found = k;
                break;
            end
        end
        check("regrant_latency", found, 12);
        req = 2'b00;
        repeat (2) tick();

        // Randomised traffic including aborts and late length changes.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
                else if (done[i]) req[i] = ($urandom_range(0, 1) == 0);
                else if ($urandom_range(0, 24) == 0) req[i] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) len0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) len1 = 4'($urandom_range(0, 15));
        end
        req = 2'b00;
        repeat (25) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
